sfft_frame_scheduler: RTL
=========================

Name: sfft_frame_scheduler

Overview:
Sequencing controller in front of and behind SFFT_Pipeline. Buffers raw audio samples in a small FIFO and issues one-cycle advance strobes with the sample held stable, never faster than the pipeline's minimum sample spacing. Watches the pipeline's output-valid and selects every 2^HOP_LOG2-th result as a hop frame for the downstream peak-finder, using a valid/ready handshake. Counts frames that are overwritten before the consumer accepts them.

Parameters:
SAMPLE_W, 16, sample width; must equal SFFT_INPUT_WIDTH
NFFT_LOG2, 8, log2 of FFT size
MIN_GAP, 129, minimum clk cycles between pipe_advance rising edges; must be >= 4 (default NFFT/2+1)
FIFO_DEPTH, 4, input sample FIFO entries
HOP_LOG2, 2, emit one frame per 2^HOP_LOG2 pipeline outputs

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  allow new advances; FIFO still accepts samples when low
sample_in  in  SAMPLE_W  raw audio sample
sample_valid  in  1  one-cycle strobe; push sample_in
pipe_sample  out  SAMPLE_W  to SampleAmplitudeIn
pipe_advance  out  1  to advanceSignal; one-cycle pulse
pipe_output_valid  in  1  from OutputValid
frame_valid  out  1  SFFT_Out currently holds an unaccepted hop frame
frame_ready  in  1  consumer has copied SFFT_Out
frame_seq  out  16  sequence number of the presented frame
drop_count  out  16  hop frames lost, saturating
fifo_overflow  out  1  sticky; a sample was discarded
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values: pipe_sample=0, pipe_advance=0, frame_valid=0, frame_seq=0, drop_count=0, fifo_overflow=0, fifo_level=0. FSM returns to IDLE. Output counter and hop counter clear.
- FIFO:
  - Push on sample_valid when not full.
  - When full, push is accepted only if a pop happens in the same cycle; otherwise the sample is discarded and fifo_overflow is set. It clears on reset only.
  - Empty plus simultaneous push and pop is not possible: a pop needs a non-empty FIFO at the start of the cycle.
- Advance FSM (IDLE, SETUP, PULSE, GAP):
  - IDLE: if enable and FIFO non-empty, pop the head into pipe_sample (registered) and go to SETUP.
  - SETUP: hold for 1 cycle, so pipe_sample is stable before the edge. Go to PULSE.
  - PULSE: pipe_advance=1 for exactly 1 cycle. Load the gap counter with MIN_GAP-3. Go to GAP.
  - GAP: decrement to 0, then go to IDLE. pipe_sample is held unchanged throughout.
- Latency: sample_valid in cycle T with an empty FIFO and the FSM in IDLE gives pipe_sample valid from T+2 and pipe_advance high in T+3.
- Back-to-back advance rising edges are exactly MIN_GAP cycles apart.
- enable deasserted in any state other than IDLE does not abort the current sequence. Only the next pop is blocked.
- Output tracking: detect the rising edge of pipe_output_valid (one event per edge, even if the level is held).
  - Each event increments an output counter (mod 2^HOP_LOG2).
  - An event is a hop event when the counter was 2^HOP_LOG2-1 before the increment, i.e. the 4th, 8th, … output for HOP_LOG2=2.
- Frame handshake, evaluated per cycle:
  - frame_ready & frame_valid: frame_valid <= 0.
  - Output event while frame_valid=1 and frame_ready=0: the frame is overwritten. drop_count increments (saturating at 0xFFFF).
  - After an overwrite, frame_valid is re-set if the new event is a hop event; otherwise it is cleared.
  - Hop event (not suppressed): frame_valid <= 1 in the next cycle. frame_seq updates to the running hop count, starting at 0.
  - Acceptance and a new hop event in the same cycle: the new frame wins. frame_valid stays 1, frame_seq advances, no drop is counted.
- Reset mid-operation: any in-flight advance, FIFO contents and pending frame are abandoned. The next sample obeys the reset latency.

Optional Feature:
SFFT_SCHED_WARMUP_EN.
- Defined: hop events are suppressed until 2^NFFT_LOG2 pipeline outputs have been observed, so the sample buffer is fully populated first. Suppressed outputs still advance the output counter.
- Undefined: hop events are presented from the first 2^HOP_LOG2-th output.

Test Plan:
- MIN_GAP=8; single sample 0x1234 at cycle T -> pipe_sample=0x1234 from T+2; pipe_advance=1 only in T+3; fifo_level returns to 0.
- 6 samples on consecutive cycles, FIFO_DEPTH=4, MIN_GAP=8 -> sample 6 discarded; fifo_overflow=1; exactly 5 advances, each exactly 8 cycles apart; pipe_sample carries samples 1–5 in order.
- HOP_LOG2=2, frame_ready tied 1, 8 output pulses (macro off) -> frame_valid on outputs 4 and 8; frame_seq 0 then 1; drop_count=0.
- frame_ready=0, HOP_LOG2=2, 5 output pulses -> frame_valid rises after output 4 and falls on output 5; drop_count=1.
- SFFT_SCHED_WARMUP_EN, NFFT_LOG2=3, HOP_LOG2=1, ready=1, 12 output pulses -> no frames for outputs 1–8; frames on outputs 10 and 12 with frame_seq 0 and 1.
- Reset asserted during GAP with 2 samples queued -> all outputs at reset values next cycle; no further pipe_advance. A new sample then advances at reset latency (T+3).

Source files
------------

// File: rtl/sfft_frame_scheduler_if.sv
// rtl/sfft_frame_scheduler_if.sv - hop-frame handshake between the scheduler and the peak-finder
//
// Purpose: carries the hop-frame valid/ready handshake and the frame sequence number.
// Signals:
//   frame_valid  master->slave  SFFT_Out holds an unaccepted hop frame
//   frame_seq    master->slave  sequence number of the presented frame (16 bits)
//   frame_ready  slave->master  consumer has copied SFFT_Out
interface sfft_frame_scheduler_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_seq;

  modport master (
    output frame_valid,
    output frame_seq,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_seq,
    output frame_ready
  );
endinterface

// File: rtl/sfft_frame_scheduler.sv
// rtl/sfft_frame_scheduler.sv - sample sequencing and hop-frame selection around SFFT_Pipeline
//
// Purpose: buffers raw samples in a small FIFO and feeds them to the pipeline as one-cycle
// advance strobes spaced at least MIN_GAP cycles apart, with the sample held stable before
// and after each strobe. Watches the pipeline output-valid and presents every
// 2^HOP_LOG2-th result as a hop frame over a valid/ready handshake, counting frames that
// are overwritten before the consumer accepts them.
//
// Optional feature macro: SFFT_SCHED_WARMUP_EN
//   defined   - hop frames are suppressed until 2^NFFT_LOG2 pipeline outputs have been seen
//   undefined - hop frames are presented from the first 2^HOP_LOG2-th output
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   enable             allow new advances (FIFO keeps accepting samples when low)
//   sample_in/valid    raw audio sample and one-cycle push strobe
//   pipe_sample        sample presented to the pipeline (registered)
//   pipe_advance       one-cycle advance pulse to the pipeline
//   pipe_output_valid  pipeline output-valid level
//   frame_if           hop-frame handshake (master side)
//   drop_count         hop frames lost to overwrite, saturating
//   fifo_overflow      sticky; a sample was discarded
//   fifo_level         current FIFO occupancy
module sfft_frame_scheduler #(
  parameter int SAMPLE_W   = 16,
  parameter int NFFT_LOG2  = 8,
  parameter int MIN_GAP    = 129,
  parameter int FIFO_DEPTH = 4,
  parameter int HOP_LOG2   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [SAMPLE_W-1:0]                sample_in,
  input  logic                               sample_valid,
  output logic [SAMPLE_W-1:0]                pipe_sample,
  output logic                               pipe_advance,
  input  logic                               pipe_output_valid,
  sfft_frame_scheduler_if.master             frame_if,
  output logic [15:0]                        drop_count,
  output logic                               fifo_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GAP_W = $clog2(MIN_GAP);

  // PULSE and SETUP/IDLE account for three cycles of the spacing; GAP covers the rest.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 3);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  if (MIN_GAP < 4 || HOP_LOG2 < 1 || NFFT_LOG2 < HOP_LOG2) begin : g_param_check
    $error("sfft_frame_scheduler: unsupported parameter combination");
  end

  // ---------------------------------------------------------------- FIFO
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                fifo_overflow_q, fifo_overflow_d;
  logic                full, push, pop;

  // ---------------------------------------------------------------- advance FSM
  logic [1:0]          state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [SAMPLE_W-1:0] pipe_sample_q, pipe_sample_d;

  // ---------------------------------------------------------------- output tracking
  logic                pov_q, pov_d;
  logic [HOP_LOG2-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]         hop_cnt_q, hop_cnt_d;
  logic                frame_valid_q, frame_valid_d;
  logic [15:0]         frame_seq_q, frame_seq_d;
  logic [15:0]         drop_count_q, drop_count_d;
  logic                out_event, hop_raw, hop_event;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop only happens from IDLE with a non-empty FIFO, so a full FIFO can still
  // take a push in the same cycle the head leaves.
  always_comb begin
    full = (level_q == LVL_W'(FIFO_DEPTH));
    pop  = (state_q == ST_IDLE) && enable && (level_q != '0);
    push = sample_valid && (!full || pop);
    fifo_overflow_d = fifo_overflow_q | (sample_valid & ~push);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = sample_in;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    pipe_sample_d = pipe_sample_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          pipe_sample_d = mem_q[rd_ptr_q];
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_PULSE;
      ST_PULSE: begin
        gap_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        // Leaving as the count reaches zero puts the next pulse exactly MIN_GAP after this one.
        if (gap_q == GAP_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One event per rising edge of the pipeline output-valid level.
  always_comb begin
    pov_d     = pipe_output_valid;
    out_event = pipe_output_valid && !pov_q;
    hop_raw   = out_event && (out_cnt_q == '1);
    out_cnt_d = out_event ? out_cnt_q + HOP_LOG2'(1) : out_cnt_q;
  end

`ifdef SFFT_SCHED_WARMUP_EN
  // Saturates at exactly 2^NFFT_LOG2; its top bit marks the sample buffer as fully populated.
  logic [NFFT_LOG2:0] warm_cnt_q, warm_cnt_d;

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (out_event && !warm_cnt_q[NFFT_LOG2]) begin
      warm_cnt_d = warm_cnt_q + (NFFT_LOG2 + 1)'(1);
    end
    hop_event = hop_raw && warm_cnt_q[NFFT_LOG2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt_q <= '0;
    end else begin
      warm_cnt_q <= warm_cnt_d;
    end
  end
`else
  always_comb begin
    hop_event = hop_raw;
  end
`endif

  // A new hop frame always wins over acceptance or overwrite of the previous one; any
  // other output event retires the presented frame.
  always_comb begin
    frame_valid_d = frame_valid_q;
    frame_seq_d   = frame_seq_q;
    hop_cnt_d     = hop_cnt_q;
    drop_count_d  = drop_count_q;
    if (out_event && frame_valid_q && !frame_if.frame_ready && drop_count_q != 16'hFFFF) begin
      drop_count_d = drop_count_q + 16'd1;
    end
    if (hop_event) begin
      frame_valid_d = 1'b1;
      frame_seq_d   = hop_cnt_q;
      hop_cnt_d     = hop_cnt_q + 16'd1;
    end else if (out_event || frame_if.frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      fifo_overflow_q <= 1'b0;
      state_q         <= ST_IDLE;
      gap_q           <= '0;
      pipe_sample_q   <= '0;
      pov_q           <= 1'b0;
      out_cnt_q       <= '0;
      hop_cnt_q       <= '0;
      frame_valid_q   <= 1'b0;
      frame_seq_q     <= '0;
      drop_count_q    <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      fifo_overflow_q <= fifo_overflow_d;
      state_q         <= state_d;
      gap_q           <= gap_d;
      pipe_sample_q   <= pipe_sample_d;
      pov_q           <= pov_d;
      out_cnt_q       <= out_cnt_d;
      hop_cnt_q       <= hop_cnt_d;
      frame_valid_q   <= frame_valid_d;
      frame_seq_q     <= frame_seq_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign pipe_sample          = pipe_sample_q;
  assign pipe_advance         = (state_q == ST_PULSE);
  assign frame_if.frame_valid = frame_valid_q;
  assign frame_if.frame_seq   = frame_seq_q;
  assign drop_count           = drop_count_q;
  assign fifo_overflow        = fifo_overflow_q;
  assign fifo_level           = level_q;

endmodule
